// File: rtl/rhs_pkg.sv
// Shared constants for the RHS2116 chip emulator: opcodes, CLEAR word, frame
// length, register count and the "INTAN" ID ROM.
package rhs_pkg;

  localparam int unsigned FrameLen = 32;
  localparam int unsigned NumRegs  = 16;

  localparam logic [1:0] OpConvert = 2'b00;
  localparam logic [1:0] OpClear   = 2'b01;
  localparam logic [1:0] OpWrite   = 2'b10;
  localparam logic [1:0] OpRead    = 2'b11;

  localparam logic [31:0] ClearWord = 32'h6A00_0000;

  localparam logic [7:0] RomAddr0 = 8'd251;
  localparam logic [7:0] RomAddr1 = 8'd252;
  localparam logic [7:0] RomAddr2 = 8'd253;
  localparam logic [7:0] RomAddr3 = 8'd254;
  localparam logic [7:0] RomAddr4 = 8'd255;

  localparam logic [7:0] RomVal0 = 8'h49;  // I
  localparam logic [7:0] RomVal1 = 8'h4E;  // N
  localparam logic [7:0] RomVal2 = 8'h54;  // T
  localparam logic [7:0] RomVal3 = 8'h41;  // A
  localparam logic [7:0] RomVal4 = 8'h4E;  // N

  // ID ROM lookup; unmapped addresses read as zero.
  function automatic logic [7:0] rom_value(input logic [7:0] addr);
    logic [7:0] val;
    val = 8'h00;
    case (addr)
      RomAddr0: val = RomVal0;
      RomAddr1: val = RomVal1;
      RomAddr2: val = RomVal2;
      RomAddr3: val = RomVal3;
      RomAddr4: val = RomVal4;
      default:  val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rhs_chip_emulator_if.sv
// SPI pins between an RHS2116 master and the chip emulator.
interface rhs_chip_emulator_if;

  logic SCLK;
  logic MOSI;
  logic CS;
  logic MISO;

  modport master (output SCLK, output MOSI, output CS, input MISO);
  modport slave  (input SCLK, input MOSI, input CS, output MISO);

endinterface

// File: rtl/rhs_emu_sync.sv
// Two-flop synchronizer with rise/fall pulses on the synchronized level.
module rhs_emu_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= ResetVal;
      s2_q   <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/rhs_chip_emulator.sv
// RHS2116 SPI responder oversampled on clk. Decodes CONVERT/READ/WRITE/CLEAR,
// keeps a 16-entry register file and ID ROM, and returns results two frames
// later on MISO.
// Optional: define RHS_EMU_FRAME_ERR_EN to count bad-length frames.
module rhs_chip_emulator
  import rhs_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  rhs_chip_emulator_if.slave  spi,
  output logic                frame_done,
  output logic [31:0]         last_cmd,
  output logic [7:0]          frame_err_cnt
);

  // Synchronizers reset low so a CS already low at reset release cannot fake
  // a falling edge; a frame only starts after CS has been seen high.
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  rhs_emu_sync #(.ResetVal(1'b0)) u_sync_sclk (
    .clk_i (clk), .rst_ni (rstn), .d_i (spi.SCLK),
    .q_o (sclk_q), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );
  rhs_emu_sync #(.ResetVal(1'b0)) u_sync_cs (
    .clk_i (clk), .rst_ni (rstn), .d_i (spi.CS),
    .q_o (cs_q), .rise_o (cs_rise), .fall_o (cs_fall)
  );
  rhs_emu_sync #(.ResetVal(1'b0)) u_sync_mosi (
    .clk_i (clk), .rst_ni (rstn), .d_i (spi.MOSI),
    .q_o (mosi_s), .rise_o (mosi_rise), .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, cs_q, mosi_rise, mosi_fall};

  logic        frame_active_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] rx_q;
  logic [31:0] shift_q;
  logic        miso_q;
  logic [31:0] pend_q, tx_word_q;
  logic [11:0] ramp_q;
  logic [15:0] regs_q [NumRegs];
  logic        frame_done_q;
  logic [31:0] last_cmd_q;

  logic accept, bad_frame;
  assign accept    = frame_active_q && cs_rise && (bit_cnt_q == 6'(FrameLen));
  assign bad_frame = frame_active_q && cs_rise && (bit_cnt_q != 6'(FrameLen));

  // Frame tracking and MOSI capture; bit count saturates so long frames stay bad.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_active_q <= 1'b0;
      bit_cnt_q      <= '0;
      rx_q           <= '0;
    end else if (cs_fall) begin
      frame_active_q <= 1'b1;
      bit_cnt_q      <= '0;
    end else if (cs_rise) begin
      frame_active_q <= 1'b0;
    end else if (frame_active_q && sclk_rise) begin
      rx_q <= {rx_q[30:0], mosi_s};
      if (bit_cnt_q != 6'h3F) bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  // MISO shifter; zero fill leaves MISO low once bit 0 has gone out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      miso_q  <= 1'b0;
    end else if (cs_fall) begin
      shift_q <= tx_word_q;
      miso_q  <= tx_word_q[31];
    end else if (!frame_active_q || cs_rise) begin
      miso_q <= 1'b0;
    end else if (sclk_fall) begin
      shift_q <= {shift_q[30:0], 1'b0};
      miso_q  <= shift_q[30];
    end
  end

  assign spi.MISO = miso_q;

  // Command decode of the captured word.
  logic [31:0] result;
  logic        wr_en, ramp_inc, ramp_clr;
  logic [7:0]  reg_addr;
  logic [5:0]  conv_ch;

  always_comb begin
    result   = '0;
    wr_en    = 1'b0;
    ramp_inc = 1'b0;
    ramp_clr = 1'b0;
    reg_addr = rx_q[23:16];
    conv_ch  = rx_q[21:16];
    case (rx_q[31:30])
      OpConvert: begin
        if (conv_ch[5:4] == 2'b00) begin
          result   = {conv_ch[3:0], ramp_q, 6'b0, ramp_q[9:0]};
          ramp_inc = 1'b1;
        end
      end
      OpWrite: begin
        result = {16'hFFFF, rx_q[15:0]};
        wr_en  = (reg_addr[7:4] == 4'h0);
      end
      OpRead: begin
        if (reg_addr[7:4] == 4'h0) result = {16'h0000, regs_q[reg_addr[3:0]]};
        else                       result = {24'h000000, rom_value(reg_addr)};
      end
      OpClear: begin
        ramp_clr = (rx_q == ClearWord);
      end
      default: result = '0;
    endcase
  end

  // Execute on an accepted frame: pipeline advance, register write, ramp.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q       <= '0;
      tx_word_q    <= '0;
      ramp_q       <= '0;
      frame_done_q <= 1'b0;
      last_cmd_q   <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      frame_done_q <= accept;
      if (accept) begin
        tx_word_q  <= pend_q;
        pend_q     <= result;
        last_cmd_q <= rx_q;
        if (wr_en) regs_q[reg_addr[3:0]] <= rx_q[15:0];
        if (ramp_clr)      ramp_q <= '0;
        else if (ramp_inc) ramp_q <= ramp_q + 12'd1;
      end
    end
  end

  assign frame_done = frame_done_q;
  assign last_cmd   = last_cmd_q;

`ifdef RHS_EMU_FRAME_ERR_EN
  logic [7:0] err_cnt_q;

  // Saturating count of discarded bad-length frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (bad_frame && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_err_cnt = err_cnt_q;
`else
  logic unused_bad_frame;
  assign unused_bad_frame = bad_frame;
  assign frame_err_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_rhs_chip_emulator.sv
// Self-checking bench for rhs_chip_emulator: bit-banged SPI master, a small
// chip model feeding a two-deep result scoreboard, and test-plan constants.
module tb_rhs_chip_emulator;

  logic        clk;
  logic        rstn;
  logic        frame_done;
  logic [31:0] last_cmd;
  logic [7:0]  frame_err_cnt;

  rhs_chip_emulator_if spi ();

  rhs_chip_emulator dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi           (spi),
    .frame_done    (frame_done),
    .last_cmd      (last_cmd),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int fd_cnt;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  // Chip model state and result scoreboard.
  logic [15:0] m_regs [16];
  logic [11:0] m_ramp;
  logic [31:0] sb [$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_ramp = 12'h0;
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
  endtask

  task automatic model_exec(input logic [31:0] cmd, output logic [31:0] res);
    logic [7:0] r;
    logic [5:0] c;
    r   = cmd[23:16];
    c   = cmd[21:16];
    res = 32'h0;
    case (cmd[31:30])
      2'b00: if (c < 6'd16) begin
        res    = {c[3:0], m_ramp, 6'b0, m_ramp[9:0]};
        m_ramp = m_ramp + 12'd1;
      end
      2'b10: begin
        res = {16'hFFFF, cmd[15:0]};
        if (r < 8'd16) m_regs[r[3:0]] = cmd[15:0];
      end
      2'b11: begin
        if (r < 8'd16) res = {16'h0, m_regs[r[3:0]]};
        else case (r)
          8'd251: res = 32'h49;
          8'd252: res = 32'h4E;
          8'd253: res = 32'h54;
          8'd254: res = 32'h41;
          8'd255: res = 32'h4E;
          default: res = 32'h0;
        endcase
      end
      default: if (cmd == 32'h6A00_0000) m_ramp = 12'h0;
    endcase
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    spi.CS   = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    #40;
    rstn = 1'b1;
    #40;
    model_reset();
  endtask

  // Bit-banged frame of nbits; returns the bits seen on MISO at SCLK rise.
  task automatic xfer(input logic [31:0] cmd, input int nbits, output logic [31:0] got);
    logic [31:0] sh;
    sh  = cmd;
    got = 32'h0;
    spi.CS   = 1'b0;
    spi.MOSI = sh[31];
    #60;
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b1;
      got = {got[30:0], spi.MISO};
      #40;
      spi.SCLK = 1'b0;
      sh = {sh[30:0], 1'b0};
      spi.MOSI = sh[31];
      #40;
    end
    spi.MOSI = 1'b0;
    spi.CS   = 1'b1;
    #80;
  endtask

  // Valid 32-bit frame: pops the expected response, pushes this frame's result.
  task automatic sb_xfer(input logic [31:0] cmd, output logic [31:0] got,
                         output logic [31:0] exp);
    logic [31:0] res;
    xfer(cmd, 32, got);
    if (sb.size() > 0) exp = sb.pop_front();
    else               exp = 32'hDEAD_BEEF;
    model_exec(cmd, res);
    sb.push_back(res);
  endtask

  localparam logic [31:0] Dummy = 32'hC000_0000;  // READ R0

  task automatic test_reset();
    rstn     = 1'b0;
    spi.CS   = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    #40;
    n_cmp++;
    if (spi.MISO !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: MISO=%b frame_done=%b, required 0 0", spi.MISO, frame_done);
    end
    rstn = 1'b1;
    #40;
    model_reset();
    n_cmp++;
    if (last_cmd !== 32'h0 || frame_err_cnt !== 8'h0) begin
      n_err++;
      $display("FAIL reset_regs: last_cmd=%h err_cnt=%h, required 0 0", last_cmd, frame_err_cnt);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] cmds [5];
    logic [31:0] req  [5];
    logic [31:0] got, exp;
    int fd0;
    cmds = '{32'h8003_1234, 32'hC003_0000, 32'hC003_0000, Dummy, Dummy};
    req  = '{32'h0, 32'h0, 32'hFFFF_1234, 32'h0000_1234, 32'h0000_1234};
    fd0  = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      sb_xfer(cmds[i], got, exp);
      n_cmp++;
      if (got !== exp || got !== req[i]) begin
        n_err++;
        $display("FAIL write_read frame %0d: got %h, required %h", i + 1, got, req[i]);
      end
    end
    n_cmp++;
    if (fd_cnt - fd0 !== 5) begin
      n_err++;
      $display("FAIL write_read frame_done: got %0d pulses, required 5", fd_cnt - fd0);
    end
    n_cmp++;
    if (last_cmd !== Dummy) begin
      n_err++;
      $display("FAIL write_read last_cmd: got %h, required %h", last_cmd, Dummy);
    end
  endtask

  task automatic test_rom();
    logic [31:0] rom [5];
    logic [31:0] got, exp;
    rom = '{32'h49, 32'h4E, 32'h54, 32'h41, 32'h4E};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] cmd;
      cmd = (i < 5) ? (32'hC000_0000 | (32'(251 + i) << 16)) : Dummy;
      sb_xfer(cmd, got, exp);
      n_cmp++;
      if (got !== exp || (i >= 2 && got !== rom[i - 2])) begin
        n_err++;
        $display("FAIL rom frame %0d: got %h, expected %h", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_convert();
    logic [31:0] cmds [5];
    logic [31:0] got, exp;
    apply_reset();
    cmds = '{32'h0005_0000, 32'h0005_0000, 32'h0014_0000, Dummy, Dummy};
    for (int i = 0; i < 5; i++) begin
      sb_xfer(cmds[i], got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL convert frame %0d: got %h, required %h", i + 1, got, exp);
      end
      if (i >= 2) begin
        n_cmp++;
        if (got !== ((i == 2) ? 32'h5000_0000 : (i == 3) ? 32'h5001_0001 : 32'h0)) begin
          n_err++;
          $display("FAIL convert_const frame %0d: got %h", i + 1, got);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] got, exp;
    int fd0;
    logic [7:0] err_req;
    fd0 = fd_cnt;
    sb_xfer(32'h8005_00AA, got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL short_pre: got %h, required %h", got, exp);
    end
    xfer(32'hC005_0000, 16, got);
    xfer(32'hC005_0000, 33, got);
    n_cmp++;
    if (fd_cnt - fd0 !== 1) begin
      n_err++;
      $display("FAIL short_no_done: got %0d pulses, required 1", fd_cnt - fd0);
    end
    n_cmp++;
    if (last_cmd !== 32'h8005_00AA) begin
      n_err++;
      $display("FAIL short_last_cmd: got %h, required 800500aa", last_cmd);
    end
`ifdef RHS_EMU_FRAME_ERR_EN
    err_req = 8'd2;
`else
    err_req = 8'd0;
`endif
    n_cmp++;
    if (frame_err_cnt !== err_req) begin
      n_err++;
      $display("FAIL short_err_cnt: got %0d, required %0d", frame_err_cnt, err_req);
    end
    for (int i = 0; i < 3; i++) begin
      sb_xfer((i == 0) ? 32'hC005_0000 : Dummy, got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL short_post frame %0d: got %h, required %h", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] cmds [7];
    logic [31:0] got, exp;
    apply_reset();
    cmds = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h6A00_0000,
             32'h0000_0000, Dummy, Dummy};
    for (int i = 0; i < 7; i++) begin
      sb_xfer(cmds[i], got, exp);
      n_cmp++;
      if (got !== exp || (i >= 5 && got !== 32'h0)) begin
        n_err++;
        $display("FAIL clear frame %0d: got %h, required %h", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got, exp;
    logic [31:0] sh;
    sb_xfer(32'h8003_BEEF, got, exp);
    sb_xfer(32'hC003_0000, got, exp);
    // Third frame shifts out the WRITE result; reset lands at bit 10.
    sh = 32'hC003_0000;
    spi.CS   = 1'b0;
    spi.MOSI = sh[31];
    #60;
    for (int i = 0; i < 10; i++) begin
      spi.SCLK = 1'b1;
      #40;
      spi.SCLK = 1'b0;
      sh = {sh[30:0], 1'b0};
      spi.MOSI = sh[31];
      #40;
    end
    n_cmp++;
    if (spi.MISO !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_miso: got %b, required 1", spi.MISO);
    end
    rstn = 1'b0;
    #2;
    n_cmp++;
    if (spi.MISO !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_miso: got %b, required 0", spi.MISO);
    end
    #8;
    spi.CS   = 1'b1;
    spi.MOSI = 1'b0;
    #40;
    rstn = 1'b1;
    #40;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      sb_xfer((i == 0) ? 32'hC003_0000 : Dummy, got, exp);
      n_cmp++;
      if (got !== exp || got !== 32'h0) begin
        n_err++;
        $display("FAIL mid_after frame %0d: got %h, required 0", i + 1, got);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    fd_cnt = 0;
    test_reset();
    test_write_read();
    test_rom();
    test_convert();
    test_short_frame();
    test_clear();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation ran past 2 ms, required completion");
    $fatal(1, "timeout");
  end

endmodule
